// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, baud divisor helper, data width.
// UART_TX_PARITY_EN adds the PARITY state to the transmit FSM encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
`endif

    function automatic int unsigned uart_div(input int unsigned clkFreq, input int unsigned baud);
        return (clkFreq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// DEPTH x 8 synchronous FIFO; read data is combinational from the head pointer.
module uart_tx_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [UART_DATA_BITS-1:0] wrData,
    output logic [UART_DATA_BITS-1:0] rdData,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]             wrPtr;
    logic [PW-1:0]             rdPtr;
    logic                      doPush;
    logic                      doPop;

    assign full   = (level == LW'(DEPTH));
    assign empty  = (level == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = mem[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            case ({doPush, doPop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed 8-bit frames, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [UART_DATA_BITS-1:0] in_data,
    output logic                      in_ready,
    output logic                      txd,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int unsigned     DIV       = uart_div(CLK_FREQ, BAUD);
    localparam int unsigned     CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   DIV_LAST  = CW'(DIV - 1);
    localparam logic [2:0]      BIT_LAST  = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

    uart_tx_state_t            state, nextState;
    logic [CW-1:0]             divCnt, divNext;
    logic [2:0]                bitIdx, bitNext;
    logic [UART_DATA_BITS-1:0] shiftReg, shiftNext;
    logic [UART_DATA_BITS-1:0] fifoData;
    logic                      txdNext;
    logic                      popReq;
    logic                      full;
    logic                      empty;
    logic                      tick;
`ifdef UART_TX_PARITY_EN
    logic                      parityReg, parityNext;
`endif

    uart_tx_fifo_mem #(
        .DEPTH (DEPTH)
    ) uFifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (in_valid),
        .pop    (popReq),
        .wrData (in_data),
        .rdData (fifoData),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );

    assign in_ready = !full;
    assign busy     = (state != IDLE) || !empty;
    assign tick     = (divCnt == DIV_LAST);

    always_comb begin
        nextState = state;
        divNext   = tick ? '0 : divCnt + CW'(1);
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        popReq    = 1'b0;
        case (state)
            IDLE: begin
                divNext = '0;
                if (!empty) begin
                    nextState = START;
                    popReq    = 1'b1;
                    shiftNext = fifoData;
                end
            end
            START: begin
                if (tick) begin
                    nextState = DATA;
                    bitNext   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bitIdx == BIT_LAST) begin
                        bitNext = '0;
`ifdef UART_TX_PARITY_EN
                        nextState = PARITY;
`else
                        nextState = STOP;
`endif
                    end else begin
                        bitNext   = bitIdx + 3'(1);
                        shiftNext = shiftReg >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    nextState = STOP;
                    bitNext   = '0;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (bitIdx == STOP_LAST) begin
                        bitNext = '0;
                        // Back-to-back: the next frame's pop happens on the stop-end edge
                        if (!empty) begin
                            nextState = START;
                            popReq    = 1'b1;
                            shiftNext = fifoData;
                        end else begin
                            nextState = IDLE;
                        end
                    end else begin
                        bitNext = bitIdx + 3'(1);
                    end
                end
            end
            default: nextState = IDLE;
        endcase

`ifdef UART_TX_PARITY_EN
        parityNext = popReq ? ^fifoData : parityReg;
`endif
        case (nextState)
            START:   txdNext = 1'b0;
            DATA:    txdNext = shiftNext[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txdNext = parityNext;
`endif
            default: txdNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            divCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            txd      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parityReg <= 1'b0;
`endif
        end else begin
            state    <= nextState;
            divCnt   <= divNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
            txd      <= txdNext;
`ifdef UART_TX_PARITY_EN
            parityReg <= parityNext;
`endif
        end
    end

endmodule
